// File: rtl/spiflash_avs_rom.sv
// Avalon-MM read-only slave in front of a fixed-latency synchronous ROM.
// Bursts of up to 3 words are expanded into sequential memory reads; returns
// are tracked by a valid/address shift pipeline matching the memory latency.
// A one-entry last-word cache answers repeated single-word reads directly.
module spiflash_avs_rom #(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 2,
   parameter bit          CACHE_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic [1:0]        avs_burstcount,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              cache_inv,
   output logic [15:0]       hit_count
);

   typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

   state_t            state_q, state_d;
   logic              ready_q;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        last_q, last_d;

   logic [MEM_LATENCY-1:0] vld_pipe_q;
   logic [ADDR_W-1:0]      adr_pipe_q [MEM_LATENCY];

   logic              cvalid_q;
   logic [ADDR_W-1:0] caddr_q;
   logic [DATA_W-1:0] cdata_q;

   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [15:0]       hits_q;

   logic accept, hit, pipe_empty, fill;

   assign pipe_empty        = (vld_pipe_q == '0);
   assign fill              = vld_pipe_q[MEM_LATENCY-1];
   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign hit_count         = hits_q;

   // State, burst base address and word index registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         base_q  <= '0;
         idx_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
         base_q  <= base_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic: accept/hit decision in IDLE, one memory read per cycle in ISSUE
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      idx_d           = idx_q;
      last_d          = last_q;
      avs_waitrequest = 1'b1;
      mem_rd          = 1'b0;
      mem_addr        = base_q + ADDR_W'(idx_q);
      accept          = 1'b0;
      hit             = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // ready_q holds waitrequest high during and just after reset
            avs_waitrequest = !ready_q;
            accept          = avs_read && ready_q;
            // hits only with nothing in flight, so responses stay in order
            hit             = CACHE_EN && accept && (avs_burstcount <= 2'd1) &&
                              cvalid_q && (avs_address == caddr_q) && pipe_empty;
            if (accept && !hit) begin
               state_d = ST_ISSUE;
               base_d  = avs_address;
               idx_d   = '0;
               last_d  = (avs_burstcount == 2'd0) ? 2'd0 : avs_burstcount - 2'd1;
            end
         end
         ST_ISSUE: begin
            mem_rd = 1'b1;
            idx_d  = idx_q + 2'd1;
            if (idx_q == last_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift pipeline marking which cycle a memory word (and its address) returns
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_pipe_q <= '0;
         for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            adr_pipe_q[i] <= '0;
         end
      end else begin
         vld_pipe_q[0] <= mem_rd;
         adr_pipe_q[0] <= mem_addr;
         for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            adr_pipe_q[i] <= adr_pipe_q[i-1];
         end
      end
   end

   // Last-word cache: every returned word refills it; invalidate beats a same-edge fill
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cvalid_q <= 1'b0;
         caddr_q  <= '0;
         cdata_q  <= '0;
      end else begin
         if (fill) begin
            caddr_q <= adr_pipe_q[MEM_LATENCY-1];
            cdata_q <= mem_rdata;
         end
         if (cache_inv) begin
            cvalid_q <= 1'b0;
         end else if (fill) begin
            cvalid_q <= 1'b1;
         end
      end
   end

   // Registered read response and saturating hit counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         hits_q   <= '0;
      end else begin
         rvalid_q <= fill || hit;
         if (fill) begin
            rdata_q <= mem_rdata;
         end else if (hit) begin
            rdata_q <= cdata_q;
         end
         if (hit && (hits_q != 16'hFFFF)) begin
            hits_q <= hits_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_spiflash_avs_rom.sv
// Directed self-checking bench for spiflash_avs_rom with a 2-cycle ROM model.
module tb_spiflash_avs_rom;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic [18:0] avs_address;
   logic        avs_read;
   logic [1:0]  avs_burstcount;
   logic        avs_waitrequest;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic [18:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata;
   logic        cache_inv;
   logic [15:0] hit_count;

   int n_cmp = 0;
   int n_bad = 0;

   spiflash_avs_rom #(
      .ADDR_W(19), .DATA_W(32), .MEM_LATENCY(LAT), .CACHE_EN(1'b1)
   ) dut (
      .clk(clk), .resetn(resetn),
      .avs_address(avs_address), .avs_read(avs_read), .avs_burstcount(avs_burstcount),
      .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .cache_inv(cache_inv), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   // ROM image: 0x00010 holds DEADBEEF, every other word is 0x52E00000 | address
   function automatic logic [31:0] memval(input logic [18:0] a);
      if (a == 19'h00010) return 32'hDEADBEEF;
      return {13'h0A5C, a};
   endfunction

   // Two-stage synchronous ROM model
   logic [31:0] m1, m2;
   always @(posedge clk) begin
      m1 <= mem_rd ? memval(mem_addr) : 32'h0;
      m2 <= m1;
   end
   assign mem_rdata = m2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present a request at the current cycle and wait (bounded) for acceptance edge
   task automatic wait_accept(input logic [18:0] a, input logic [1:0] bc, output bit ok);
      avs_address    = a;
      avs_burstcount = bc;
      avs_read       = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (!avs_waitrequest) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("accept_timeout", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      avs_read = 1'b0;
   endtask

   // One read transaction, observed for 16 cycles after the accept edge
   task automatic run_read(input logic [18:0] a, input logic [1:0] bc, input bit exp_hit,
                           input logic [15:0] exp_hits, input logic [31:0] exp_d0,
                           input int inv_cyc);
      int b, nrd, nw, nwr, first;
      bit ok;
      b = (bc == 2'd0) ? 1 : int'(bc);
      nrd = 0; nw = 0; nwr = 0; first = -1;
      wait_accept(a, bc, ok);
      if (!ok) return;
      for (int c = 1; c <= 16; c++) begin
         cache_inv = (c == inv_cyc);
         if (mem_rd) begin
            chk("mem_addr", {13'd0, mem_addr}, {13'd0, a + 19'(nrd)});
            nrd++;
         end
         if (avs_waitrequest) nwr++;
         if (avs_readdatavalid) begin
            if (nw == 0) first = c;
            chk("rdata", avs_readdata, (nw == 0) ? exp_d0 : memval(a + 19'(nw)));
            chk("rv_consecutive", c, first + nw);
            nw++;
         end
         @(posedge clk); #1;
      end
      cache_inv = 1'b0;
      chk("word_count", nw, b);
      chk("mem_rd_count", nrd, exp_hit ? 0 : b);
      chk("waitreq_cycles", nwr, exp_hit ? 0 : b);
      chk("first_latency", first, exp_hit ? 1 : 2 + LAT);
      chk("hit_count", {16'd0, hit_count}, {16'd0, exp_hits});
   endtask

   typedef struct {
      logic [18:0] addr;
      logic [1:0]  bc;
      bit          hit;
      logic [15:0] hits;
      logic [31:0] d0;
   } vec_t;

   vec_t vec [9];

   initial begin
      int nrd, nw;
      bit ok;
      logic [31:0] words [4];

      vec[0] = '{19'h00010, 2'd1, 1'b0, 16'd0, 32'hDEADBEEF};
      vec[1] = '{19'h00010, 2'd1, 1'b1, 16'd1, 32'hDEADBEEF};
      vec[2] = '{19'h7FFFE, 2'd3, 1'b0, 16'd1, 32'h52E7FFFE};
      vec[3] = '{19'h00000, 2'd1, 1'b1, 16'd2, 32'h52E00000};
      vec[4] = '{19'h00020, 2'd0, 1'b0, 16'd2, 32'h52E00020};
      vec[5] = '{19'h00020, 2'd2, 1'b0, 16'd2, 32'h52E00020};
      vec[6] = '{19'h00021, 2'd0, 1'b1, 16'd3, 32'h52E00021};
      vec[7] = '{19'h00021, 2'd1, 1'b1, 16'd4, 32'h52E00021};
      vec[8] = '{19'h00010, 2'd1, 1'b0, 16'd4, 32'hDEADBEEF};

      resetn = 1'b0; avs_address = '0; avs_read = 1'b0; avs_burstcount = '0; cache_inv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
      chk("rst_rvalid", {31'd0, avs_readdatavalid}, 32'd0);
      chk("rst_memrd", {31'd0, mem_rd}, 32'd0);
      chk("rst_hits", {16'd0, hit_count}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_read(vec[i].addr, vec[i].bc, vec[i].hit, vec[i].hits, vec[i].d0, 0);
      end

      // Invalidate on the same edge as the fill: the following read must miss
      run_read(19'h00030, 2'd1, 1'b0, 16'd4, 32'h52E00030, 1 + LAT);
      run_read(19'h00030, 2'd1, 1'b0, 16'd4, 32'h52E00030, 0);

      // Cached address requested while another word is in flight: handled as a miss
      wait_accept(19'h00031, 2'd1, ok);
      avs_read = 1'b1;
      avs_address = 19'h00030;
      nrd = 0; nw = 0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 2) chk("b2b_accept", {31'd0, avs_waitrequest}, 32'd0);
         if (c == 3) avs_read = 1'b0;
         if (mem_rd) nrd++;
         if (avs_readdatavalid) begin
            if (nw < 4) words[nw] = avs_readdata;
            nw++;
         end
         @(posedge clk); #1;
      end
      avs_read = 1'b0;
      chk("b2b_mem_rd", nrd, 2);
      chk("b2b_words", nw, 2);
      chk("b2b_word0", words[0], 32'h52E00031);
      chk("b2b_word1", words[1], 32'h52E00030);
      chk("b2b_hits", {16'd0, hit_count}, 32'd4);

      // Reset while a 3-word burst is in flight
      wait_accept(19'h00100, 2'd3, ok);
      @(posedge clk); #3;
      resetn = 1'b0;
      #1;
      chk("mid_rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
      chk("mid_rst_memrd", {31'd0, mem_rd}, 32'd0);
      chk("mid_rst_rvalid", {31'd0, avs_readdatavalid}, 32'd0);
      chk("mid_rst_rdata", avs_readdata, 32'd0);
      chk("mid_rst_hits", {16'd0, hit_count}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;
      nw = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (avs_readdatavalid) nw++;
      end
      chk("post_rst_rvalid", nw, 0);
      chk("post_rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
      chk("post_rst_hits", {16'd0, hit_count}, 32'd0);
      // Cache was cleared by reset: 0x30 misses once, then hits
      run_read(19'h00030, 2'd1, 1'b0, 16'd0, 32'h52E00030, 0);
      run_read(19'h00030, 2'd1, 1'b1, 16'd1, 32'h52E00030, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
